// File: rtl/term_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : term_ctrl_if
// Description : Host byte handshake and terminal-core write port bundle for
//               term_ctrl. The host is the master; term_ctrl is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface term_ctrl_if;
    logic [7:0] in_data;
    logic       in_stb;
    logic       in_ready;
    logic [7:0] data;
    logic       dstrobe;
    logic [1:0] dtype;
    logic [4:0] row;
    logic [6:0] col;

    modport master (
        output in_data, in_stb,
        input  in_ready, data, dstrobe, dtype, row, col
    );

    modport slave (
        input  in_data, in_stb,
        output in_ready, data, dstrobe, dtype, row, col
    );
endinterface
`default_nettype wire

// File: rtl/term_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : term_ctrl
// Description : Byte-stream front end for the terminal core. Decodes control
//               codes and the ESC Y row col escape, emits single-cycle write
//               strobes, tracks a shadow cursor and runs clear-screen fills.
// Revision    : 1.0 - initial release
// ============================================================================
module term_ctrl #(
    parameter int         ROWS = 30,
    parameter int         COLS = 80,
    parameter logic [7:0] FILL = 8'h20
) (
    input  wire logic  CLK_I,
    input  wire logic  RST_I,
    term_ctrl_if.slave bus
);

    localparam logic [4:0]  c_last_row  = 5'(ROWS - 1);
    localparam logic [6:0]  c_last_col  = 7'(COLS - 1);
    localparam logic [11:0] c_fill_last = 12'(ROWS * COLS - 1);
    localparam logic [1:0]  c_dt_char   = 2'd0;
    localparam logic [1:0]  c_dt_col    = 2'd1;
    localparam logic [1:0]  c_dt_row    = 2'd2;

    typedef enum logic [3:0] {
        INIT_COL, INIT_ROW, IDLE, CMD, FIX_ROW, ESC, ESC_Y, ESC_R,
        SET_ROW, SET_COL, CLR_ROW, CLR_COL, CLR_FILL, CLR_END
    } state_t;

    state_t      r_state;
    logic [7:0]  r_data;
    logic        r_dstrobe;
    logic [1:0]  r_dtype;
    logic        r_in_ready;
    logic [4:0]  r_row;
    logic [6:0]  r_col;
    logic [11:0] r_cnt;
    logic [4:0]  r_esc_row;
    logic [6:0]  r_esc_col;

    logic        w_accept;
    logic [7:0]  w_byte;
    logic        w_printable;
    logic        w_wrap;
    logic [4:0]  w_lf_row;
    logic [7:0]  w_tab_sum;
    logic [6:0]  w_tab_col;
    logic [7:0]  w_off;
    logic [4:0]  w_row_clamp;
    logic [6:0]  w_col_clamp;

    // Byte decode helpers: printable test, wrap detect, LF/TAB targets and
    // escape coordinate clamping (bytes below 0x20 clamp to 0).
    always_comb begin
        w_accept    = r_in_ready & bus.in_stb;
        w_byte      = bus.in_data;
        w_printable = (w_byte >= 8'h20) && (w_byte != 8'h7F);
        w_wrap      = (r_col == c_last_col) && (r_row == c_last_row);
        w_lf_row    = (r_row >= c_last_row) ? 5'd0 : r_row + 5'd1;
        w_tab_sum   = {1'b0, r_col | 7'd7} + 8'd1;
        w_tab_col   = (w_tab_sum > {1'b0, c_last_col}) ? c_last_col : w_tab_sum[6:0];
        w_off       = w_byte - 8'd32;
        w_row_clamp = 5'd0;
        w_col_clamp = 7'd0;
        if (w_byte >= 8'd32) begin
            w_row_clamp = (w_off > {3'b0, c_last_row}) ? c_last_row : w_off[4:0];
            w_col_clamp = (w_off > {1'b0, c_last_col}) ? c_last_col : w_off[6:0];
        end
    end

    // Control FSM: each transition also loads the registered strobe outputs
    // for the cycle that follows, so the first strobe of a command appears
    // the cycle after the byte is accepted.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state    <= INIT_COL;
            r_data     <= 8'd0;
            r_dstrobe  <= 1'b0;
            r_dtype    <= c_dt_char;
            r_in_ready <= 1'b0;
            r_cnt      <= 12'd0;
            r_esc_row  <= 5'd0;
            r_esc_col  <= 7'd0;
        end else begin
            r_dstrobe <= 1'b0;
            case (r_state)
                INIT_COL: begin
                    r_dstrobe <= 1'b1; r_dtype <= c_dt_col; r_data <= 8'd0;
                    r_state   <= INIT_ROW;
                end
                INIT_ROW: begin
                    r_dstrobe <= 1'b1; r_dtype <= c_dt_row; r_data <= 8'd0;
                    r_state   <= CMD;
                end
                CMD: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
                IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_state    <= CMD;
                        if (w_printable) begin
                            r_dstrobe <= 1'b1; r_dtype <= c_dt_char; r_data <= w_byte;
                            // Core wraps to row 30 here; pull it back to row 0.
                            if (w_wrap) r_state <= FIX_ROW;
                        end else begin
                            case (w_byte)
                                8'h0D: begin
                                    r_dstrobe <= 1'b1; r_dtype <= c_dt_col; r_data <= 8'd0;
                                end
                                8'h0A: begin
                                    r_dstrobe <= 1'b1; r_dtype <= c_dt_row; r_data <= {3'b0, w_lf_row};
                                end
                                8'h08: begin
                                    if (r_col != 7'd0) begin
                                        r_dstrobe <= 1'b1; r_dtype <= c_dt_col;
                                        r_data    <= {1'b0, r_col - 7'd1};
                                    end
                                end
                                8'h09: begin
                                    r_dstrobe <= 1'b1; r_dtype <= c_dt_col; r_data <= {1'b0, w_tab_col};
                                end
                                8'h0C: begin
                                    r_dstrobe <= 1'b1; r_dtype <= c_dt_row; r_data <= 8'd0;
                                    r_state   <= CLR_ROW;
                                end
                                8'h1B: begin
                                    r_state    <= ESC;
                                    r_in_ready <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                FIX_ROW: begin
                    r_dstrobe <= 1'b1; r_dtype <= c_dt_row; r_data <= 8'd0;
                    r_state   <= CMD;
                end
                ESC: begin
                    if (w_accept) r_state <= (w_byte == 8'h59) ? ESC_Y : IDLE;
                end
                ESC_Y: begin
                    if (w_accept) begin
                        r_esc_row <= w_row_clamp;
                        r_state   <= ESC_R;
                    end
                end
                ESC_R: begin
                    if (w_accept) begin
                        r_esc_col  <= w_col_clamp;
                        r_in_ready <= 1'b0;
                        r_dstrobe  <= 1'b1; r_dtype <= c_dt_row; r_data <= {3'b0, r_esc_row};
                        r_state    <= SET_ROW;
                    end
                end
                SET_ROW: begin
                    r_dstrobe <= 1'b1; r_dtype <= c_dt_col; r_data <= {1'b0, r_esc_col};
                    r_state   <= SET_COL;
                end
                SET_COL: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
                CLR_ROW: begin
                    r_dstrobe <= 1'b1; r_dtype <= c_dt_col; r_data <= 8'd0;
                    r_state   <= CLR_COL;
                end
                CLR_COL: begin
                    r_dstrobe <= 1'b1; r_dtype <= c_dt_char; r_data <= FILL;
                    r_cnt     <= 12'd0;
                    r_state   <= CLR_FILL;
                end
                CLR_FILL: begin
                    r_dstrobe <= 1'b1;
                    if (r_cnt == c_fill_last) begin
                        r_dtype <= c_dt_row; r_data <= 8'd0;
                        r_state <= CLR_END;
                    end else begin
                        r_dtype <= c_dt_char; r_data <= FILL;
                        r_cnt   <= r_cnt + 12'd1;
                    end
                end
                CLR_END: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
                default: r_state <= INIT_COL;
            endcase
        end
    end

    // Shadow cursor follows the core's own update rules on each strobe.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_row <= 5'd0;
            r_col <= 7'd0;
        end else if (r_dstrobe) begin
            case (r_dtype)
                c_dt_char: begin
                    if (r_col == c_last_col) begin
                        r_col <= 7'd0;
                        r_row <= r_row + 5'd1;
                    end else begin
                        r_col <= r_col + 7'd1;
                    end
                end
                c_dt_col: r_col <= r_data[6:0];
                c_dt_row: r_row <= r_data[4:0];
                default:  ;
            endcase
        end
    end

    assign bus.data     = r_data;
    assign bus.dstrobe  = r_dstrobe;
    assign bus.dtype    = r_dtype;
    assign bus.in_ready = r_in_ready;
    assign bus.row      = r_row;
    assign bus.col      = r_col;

endmodule
`default_nettype wire

// File: tb/tb_term_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_term_ctrl
// Description : Directed self-checking bench for term_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_term_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [9:0] log_q[$];

    term_ctrl_if bus();

    term_ctrl #(.ROWS(30), .COLS(80), .FILL(8'h20)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every strobe as {dtype, data}
    always @(posedge clk) begin
        if (bus.dstrobe === 1'b1) log_q.push_back({bus.dtype, bus.data});
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 3000) begin
            tick();
            waited++;
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_wait: in_ready=%b required 1 (byte %h)", bus.in_ready, b);
        end
        bus.in_data = b;
        bus.in_stb  = 1'b1;
        tick();
        bus.in_stb  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({bus.dstrobe, bus.in_ready, bus.dtype, bus.data, bus.row, bus.col} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_values: got stb=%b rdy=%b dt=%0d d=%h r=%0d c=%0d required all 0",
                     bus.dstrobe, bus.in_ready, bus.dtype, bus.data, bus.row, bus.col);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({bus.dstrobe, bus.dtype, bus.data, bus.in_ready} !== {1'b1, 2'd1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL home_col: got stb=%b dt=%0d d=%h rdy=%b required 1/1/00/0",
                     bus.dstrobe, bus.dtype, bus.data, bus.in_ready);
        end
        tick();
        n_checks++;
        if ({bus.dstrobe, bus.dtype, bus.data, bus.in_ready} !== {1'b1, 2'd2, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL home_row: got stb=%b dt=%0d d=%h rdy=%b required 1/2/00/0",
                     bus.dstrobe, bus.dtype, bus.data, bus.in_ready);
        end
        tick();
        n_checks++;
        if ({bus.in_ready, bus.dstrobe, bus.row, bus.col} !== {1'b1, 1'b0, 5'd0, 7'd0}) begin
            n_fail++;
            $display("FAIL home_done: got rdy=%b stb=%b r=%0d c=%0d required 1/0/0/0",
                     bus.in_ready, bus.dstrobe, bus.row, bus.col);
        end
    endtask

    task automatic test_char_cr_lf();
        send_byte(8'h41);
        n_checks++;
        if ({bus.dstrobe, bus.dtype, bus.data, bus.in_ready} !== {1'b1, 2'd0, 8'h41, 1'b0}) begin
            n_fail++;
            $display("FAIL char_A: got stb=%b dt=%0d d=%h rdy=%b required 1/0/41/0",
                     bus.dstrobe, bus.dtype, bus.data, bus.in_ready);
        end
        tick();
        n_checks++;
        if ({bus.in_ready, bus.dstrobe, bus.row, bus.col} !== {1'b1, 1'b0, 5'd0, 7'd1}) begin
            n_fail++;
            $display("FAIL char_A_after: got rdy=%b stb=%b r=%0d c=%0d required 1/0/0/1",
                     bus.in_ready, bus.dstrobe, bus.row, bus.col);
        end
        send_byte(8'h0D);
        n_checks++;
        if ({bus.dstrobe, bus.dtype, bus.data} !== {1'b1, 2'd1, 8'h00}) begin
            n_fail++;
            $display("FAIL cr: got stb=%b dt=%0d d=%h required 1/1/00", bus.dstrobe, bus.dtype, bus.data);
        end
        send_byte(8'h0A);
        n_checks++;
        if ({bus.dstrobe, bus.dtype, bus.data} !== {1'b1, 2'd2, 8'h01}) begin
            n_fail++;
            $display("FAIL lf: got stb=%b dt=%0d d=%h required 1/2/01", bus.dstrobe, bus.dtype, bus.data);
        end
        tick();
        n_checks++;
        if ({bus.row, bus.col} !== {5'd1, 7'd0}) begin
            n_fail++;
            $display("FAIL lf_after: got r=%0d c=%0d required 1/0", bus.row, bus.col);
        end
    endtask

    task automatic test_wrap();
        send_byte(8'h1B);
        n_checks++;
        if ({bus.in_ready, bus.dstrobe} !== 2'b10) begin
            n_fail++;
            $display("FAIL esc_ready: got rdy=%b stb=%b required 1/0", bus.in_ready, bus.dstrobe);
        end
        send_byte(8'h59);
        send_byte(8'h3D);
        send_byte(8'h6F);
        n_checks++;
        if ({bus.dstrobe, bus.dtype, bus.data, bus.in_ready} !== {1'b1, 2'd2, 8'd29, 1'b0}) begin
            n_fail++;
            $display("FAIL esc_row: got stb=%b dt=%0d d=%0d rdy=%b required 1/2/29/0",
                     bus.dstrobe, bus.dtype, bus.data, bus.in_ready);
        end
        tick();
        n_checks++;
        if ({bus.dstrobe, bus.dtype, bus.data, bus.in_ready} !== {1'b1, 2'd1, 8'd79, 1'b0}) begin
            n_fail++;
            $display("FAIL esc_col: got stb=%b dt=%0d d=%0d rdy=%b required 1/1/79/0",
                     bus.dstrobe, bus.dtype, bus.data, bus.in_ready);
        end
        tick();
        n_checks++;
        if ({bus.in_ready, bus.row, bus.col} !== {1'b1, 5'd29, 7'd79}) begin
            n_fail++;
            $display("FAIL esc_done: got rdy=%b r=%0d c=%0d required 1/29/79", bus.in_ready, bus.row, bus.col);
        end
        send_byte(8'h5A);
        n_checks++;
        if ({bus.dstrobe, bus.dtype, bus.data} !== {1'b1, 2'd0, 8'h5A}) begin
            n_fail++;
            $display("FAIL wrap_char: got stb=%b dt=%0d d=%h required 1/0/5A", bus.dstrobe, bus.dtype, bus.data);
        end
        tick();
        n_checks++;
        if ({bus.dstrobe, bus.dtype, bus.data, bus.in_ready} !== {1'b1, 2'd2, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_row: got stb=%b dt=%0d d=%h rdy=%b required 1/2/00/0",
                     bus.dstrobe, bus.dtype, bus.data, bus.in_ready);
        end
        tick();
        n_checks++;
        if ({bus.in_ready, bus.row, bus.col} !== {1'b1, 5'd0, 7'd0}) begin
            n_fail++;
            $display("FAIL wrap_done: got rdy=%b r=%0d c=%0d required 1/0/0", bus.in_ready, bus.row, bus.col);
        end
    endtask

    task automatic test_clamp_and_codes();
        int s;
        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h7F); send_byte(8'hFF);
        repeat (2) tick();
        n_checks++;
        if ({bus.in_ready, bus.row, bus.col} !== {1'b1, 5'd29, 7'd79}) begin
            n_fail++;
            $display("FAIL clamp: got rdy=%b r=%0d c=%0d required 1/29/79", bus.in_ready, bus.row, bus.col);
        end
        // Aborted escape, DEL and BS at column 0 all produce no strobe
        send_byte(8'h0D);
        tick();
        s = log_q.size();
        send_byte(8'h1B);
        send_byte(8'h51);
        n_checks++;
        if ({bus.in_ready, bus.dstrobe} !== 2'b10) begin
            n_fail++;
            $display("FAIL esc_abort: got rdy=%b stb=%b required 1/0", bus.in_ready, bus.dstrobe);
        end
        send_byte(8'h7F);
        send_byte(8'h08);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bs_busy: got rdy=%b required 0", bus.in_ready);
        end
        repeat (3) tick();
        n_checks++;
        if ((log_q.size() - s) != 0 || bus.col !== 7'd0) begin
            n_fail++;
            $display("FAIL no_strobe: got %0d strobes col=%0d required 0 strobes col=0", log_q.size() - s, bus.col);
        end
        // TAB from column 75 clamps to 79
        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h20); send_byte(8'h6B);
        repeat (2) tick();
        n_checks++;
        if ({bus.row, bus.col} !== {5'd0, 7'd75}) begin
            n_fail++;
            $display("FAIL goto_75: got r=%0d c=%0d required 0/75", bus.row, bus.col);
        end
        send_byte(8'h09);
        n_checks++;
        if ({bus.dstrobe, bus.dtype, bus.data} !== {1'b1, 2'd1, 8'd79}) begin
            n_fail++;
            $display("FAIL tab: got stb=%b dt=%0d d=%0d required 1/1/79", bus.dstrobe, bus.dtype, bus.data);
        end
        // BS from column 79
        send_byte(8'h08);
        n_checks++;
        if ({bus.dstrobe, bus.dtype, bus.data} !== {1'b1, 2'd1, 8'd78}) begin
            n_fail++;
            $display("FAIL bs: got stb=%b dt=%0d d=%0d required 1/1/78", bus.dstrobe, bus.dtype, bus.data);
        end
        tick();
    endtask

    task automatic test_clear();
        int s;
        int low = 0;
        int bad = 0;
        s = log_q.size();
        send_byte(8'h0C);
        while (bus.in_ready !== 1'b1 && low < 3000) begin
            low++;
            tick();
        end
        n_checks++;
        if (low != 2403) begin
            n_fail++;
            $display("FAIL clr_busy: got %0d busy cycles required 2403", low);
        end
        n_checks++;
        if (log_q.size() - s != 2403) begin
            n_fail++;
            $display("FAIL clr_count: got %0d strobes required 2403", log_q.size() - s);
        end else begin
            for (int i = 2; i < 2402; i++) begin
                if (log_q[s + i] !== {2'd0, 8'h20}) bad++;
            end
            n_checks++;
            if (log_q[s] !== {2'd2, 8'h00} || log_q[s + 1] !== {2'd1, 8'h00} ||
                log_q[s + 2402] !== {2'd2, 8'h00} || bad != 0) begin
                n_fail++;
                $display("FAIL clr_frame: got first=%h second=%h last=%h badfill=%0d required 200/100/200/0",
                         log_q[s], log_q[s + 1], log_q[s + 2402], bad);
            end
        end
        n_checks++;
        if ({bus.row, bus.col} !== {5'd0, 7'd0}) begin
            n_fail++;
            $display("FAIL clr_cursor: got r=%0d c=%0d required 0/0", bus.row, bus.col);
        end
    endtask

    task automatic test_reset_mid_fill();
        send_byte(8'h0C);
        repeat (1001) tick();
        n_checks++;
        if ({bus.dstrobe, bus.dtype, bus.data} !== {1'b1, 2'd0, 8'h20}) begin
            n_fail++;
            $display("FAIL fill_1000: got stb=%b dt=%0d d=%h required 1/0/20", bus.dstrobe, bus.dtype, bus.data);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({bus.dstrobe, bus.in_ready, bus.row, bus.col} !== {1'b0, 1'b0, 5'd0, 7'd0}) begin
            n_fail++;
            $display("FAIL abort_fill: got stb=%b rdy=%b r=%0d c=%0d required 0/0/0/0",
                     bus.dstrobe, bus.in_ready, bus.row, bus.col);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({bus.dstrobe, bus.dtype} !== {1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL rehome_col: got stb=%b dt=%0d required 1/1", bus.dstrobe, bus.dtype);
        end
        tick();
        n_checks++;
        if ({bus.dstrobe, bus.dtype} !== {1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL rehome_row: got stb=%b dt=%0d required 1/2", bus.dstrobe, bus.dtype);
        end
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rehome_ready: got rdy=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_escape();
        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        send_byte(8'h42);
        n_checks++;
        if ({bus.dstrobe, bus.dtype, bus.data} !== {1'b1, 2'd0, 8'h42}) begin
            n_fail++;
            $display("FAIL esc_discard: got stb=%b dt=%0d d=%h required 1/0/42", bus.dstrobe, bus.dtype, bus.data);
        end
        tick();
        n_checks++;
        if ({bus.row, bus.col} !== {5'd0, 7'd1}) begin
            n_fail++;
            $display("FAIL esc_discard_cur: got r=%0d c=%0d required 0/1", bus.row, bus.col);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.in_stb  = 1'b0;
        bus.in_data = 8'h00;
        test_reset();
        test_char_cr_lf();
        test_wrap();
        test_clamp_and_codes();
        test_clear();
        test_reset_mid_fill();
        test_reset_mid_escape();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
